// File: rtl/ifm_row_loader_pkg.sv
// Shared widths, FSM state encoding and address helper for the IFM row loader.
// Used by ifm_row_loader, its address generator and its bus interface.
package ifm_row_loader_pkg;
    localparam int W_SIZE         = 10;
    localparam int W_CHANNEL      = 10;
    localparam int IFM_BUF_CNT    = 4;
    localparam int W_IFM_BUF      = 2;
    localparam int W_ADDR         = 32;
    localparam int W_DATA         = 64;
    localparam int W_BUF_ADDR     = 12;
    localparam int MAX_OUTST      = 8;
    localparam int W_CNT          = W_SIZE + W_CHANNEL;
    localparam int BYTES_PER_WORD = W_DATA / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Word index to byte offset, wrapping in W_ADDR bits.
    function automatic logic [W_ADDR-1:0] word_to_byte(input logic [W_ADDR-1:0] w);
        return w * W_ADDR'(BYTES_PER_WORD);
    endfunction
endpackage

// File: rtl/ifm_row_loader_if.sv
// Request, memory read and row-bank write signals of the IFM row loader.
// master = loader side, slave = controller/memory/buffer side.
interface ifm_row_loader_if import ifm_row_loader_pkg::*; ();
    logic [W_SIZE-1:0]     q_width;
    logic [W_SIZE-1:0]     q_height;
    logic [W_CHANNEL-1:0]  q_channel;
    logic [W_ADDR-1:0]     q_base_addr;
    logic                  i_req_load;
    logic [W_SIZE-1:0]     i_req_row;
    logic                  o_req_done;
    logic                  o_busy;
    logic                  o_rd_req;
    logic [W_ADDR-1:0]     o_rd_addr;
    logic                  i_rd_ready;
    logic                  i_rd_vld;
    logic [W_DATA-1:0]     i_rd_data;
    logic                  o_buf_we;
    logic [W_IFM_BUF-1:0]  o_buf_bank;
    logic [W_BUF_ADDR-1:0] o_buf_addr;
    logic [W_DATA-1:0]     o_buf_wdata;

    modport master (
        input  q_width, q_height, q_channel, q_base_addr,
        input  i_req_load, i_req_row, i_rd_ready, i_rd_vld, i_rd_data,
        output o_req_done, o_busy, o_rd_req, o_rd_addr,
        output o_buf_we, o_buf_bank, o_buf_addr, o_buf_wdata
    );

    modport slave (
        output q_width, q_height, q_channel, q_base_addr,
        output i_req_load, i_req_row, i_rd_ready, i_rd_vld, i_rd_data,
        input  o_req_done, o_busy, o_rd_req, o_rd_addr,
        input  o_buf_we, o_buf_bank, o_buf_addr, o_buf_wdata
    );
endinterface

// File: rtl/ifm_row_loader_addr_gen.sv
// Row address generator: latches the requested row, computes row base address,
// word count and bank in ADDR, then steps the read address per accepted request.
module ifm_row_loader_addr_gen import ifm_row_loader_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic                 load,
    input  logic                 step,
    input  logic [W_SIZE-1:0]    row,
    input  logic [W_SIZE-1:0]    width,
    input  logic [W_CHANNEL-1:0] channel,
    input  logic [W_ADDR-1:0]    base_addr,
    output logic [W_CNT-1:0]     words_now,
    output logic [W_CNT-1:0]     words,
    output logic [W_IFM_BUF-1:0] bank,
    output logic [W_ADDR-1:0]    rd_addr
);
    logic [W_SIZE-1:0] row_q;
    logic [W_ADDR-1:0] row_off;

    assign words_now = W_CNT'(width) * W_CNT'(channel);
    assign row_off   = word_to_byte(W_ADDR'(row_q) * W_ADDR'(words_now));

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            words   <= '0;
            bank    <= '0;
            rd_addr <= '0;
        end else begin
            if (accept)
                row_q <= row;
            if (load) begin
                words   <= words_now;
                bank    <= row_q[W_IFM_BUF-1:0];
                rd_addr <= base_addr + row_off;
            end else if (step) begin
                rd_addr <= rd_addr + W_ADDR'(BYTES_PER_WORD);
            end
        end
    end
endmodule

// File: rtl/ifm_row_loader.sv
// IFM row loader: fetches one tiled row from memory into row bank (row mod IFM_BUF_CNT).
// Optional IFM_ROW_LOADER_PERF_EN adds o_perf_stall_cnt (FETCH cycles with request not accepted).
module ifm_row_loader import ifm_row_loader_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    ifm_row_loader_if.master      bus
`ifdef IFM_ROW_LOADER_PERF_EN
    ,
    output logic [31:0]           o_perf_stall_cnt
`endif
);
    state_e               state;
    logic [W_CNT-1:0]     issued;
    logic [W_CNT-1:0]     received;
    logic [W_CNT-1:0]     words;
    logic [W_CNT-1:0]     words_now;
    logic [W_IFM_BUF-1:0] bank;
    logic                 accept;
    logic                 issue;
    logic                 beat;

    assign accept = (state == ST_IDLE) && bus.i_req_load && (bus.i_req_row < bus.q_height);
    assign bus.o_rd_req = (state == ST_FETCH) && (issued < words)
                          && ((issued - received) < W_CNT'(MAX_OUTST));
    assign issue = bus.o_rd_req && bus.i_rd_ready;
    // Beats outside FETCH or beyond the row length are dropped.
    assign beat  = (state == ST_FETCH) && bus.i_rd_vld && (received < words);

    ifm_row_loader_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .load      (state == ST_ADDR),
        .step      (issue),
        .row       (bus.i_req_row),
        .width     (bus.q_width),
        .channel   (bus.q_channel),
        .base_addr (bus.q_base_addr),
        .words_now (words_now),
        .words     (words),
        .bank      (bank),
        .rd_addr   (bus.o_rd_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            issued          <= '0;
            received        <= '0;
            bus.o_req_done  <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_buf_we    <= 1'b0;
            bus.o_buf_bank  <= '0;
            bus.o_buf_addr  <= '0;
            bus.o_buf_wdata <= '0;
        end else begin
            bus.o_req_done <= 1'b0;
            bus.o_buf_we   <= beat;
            if (beat) begin
                bus.o_buf_bank  <= bank;
                bus.o_buf_addr  <= received[W_BUF_ADDR-1:0];
                bus.o_buf_wdata <= bus.i_rd_data;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_ADDR;
                        bus.o_busy <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    issued   <= '0;
                    received <= '0;
                    if (words_now == '0) begin
                        state          <= ST_DONE;
                        bus.o_req_done <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (issue)
                        issued <= issued + W_CNT'(1);
                    if (beat)
                        received <= received + W_CNT'(1);
                    // The write in flight while all beats are counted is the last one.
                    if (bus.o_buf_we && (received == words)) begin
                        state          <= ST_DONE;
                        bus.o_req_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IFM_ROW_LOADER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            o_perf_stall_cnt <= '0;
        else if (bus.o_rd_req && !bus.i_rd_ready && (o_perf_stall_cnt != 32'hFFFF_FFFF))
            o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ifm_row_loader.sv
// Self-checking bench for ifm_row_loader: in-order memory responder, row-level model
// and a per-cycle compare process, plus directed literal checks.
`timescale 1ns/1ps
module tb_ifm_row_loader;
    import ifm_row_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifm_row_loader_if bus ();

`ifdef IFM_ROW_LOADER_PERF_EN
    logic [31:0] perf_cnt;
`endif

    ifm_row_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFM_ROW_LOADER_PERF_EN
        ,
        .o_perf_stall_cnt (perf_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mdata(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a};
    endfunction

    // memory responder
    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } rd_t;
    rd_t q[$];
    int  cyc = 0;
    int  lat = 3;
    int  rdy_alt = 0;
    int  stall_left = 0;
    bit  stray_after_last = 0;
    bit  stray_now = 0;

    initial begin
        bus.i_rd_ready = 1'b0;
        bus.i_rd_vld   = 1'b0;
        bus.i_rd_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.i_rd_ready = (rdy_alt != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (stall_left > 0) begin
                bus.i_rd_ready = 1'b0;
                stall_left--;
            end
            if (stray_now) begin
                bus.i_rd_vld  = 1'b1;
                bus.i_rd_data = mdata(32'hBAD0_0000);
                stray_now = 0;
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                bus.i_rd_vld  = 1'b1;
                bus.i_rd_data = mdata(q[0].addr);
                void'(q.pop_front());
                if (q.size() == 0 && stray_after_last) begin
                    stray_now = 1;
                    stray_after_last = 0;
                end
            end else begin
                bus.i_rd_vld = 1'b0;
            end
            #2;
            if (bus.o_rd_req && bus.i_rd_ready)
                q.push_back('{addr: bus.o_rd_addr, due: cyc + lat});
        end
    end

    // row model and compare process
    bit          active = 0;
    int          m_words, m_iss, m_rcv, m_wr, m_bank;
    logic [31:0] m_row_addr;
    int          done_cnt = 0;
    int          last_beat_cyc = 0;
    int          max_outst = 0;
    logic [31:0] last_rd_addr = '0;
    int          last_bank = -1;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            chk("busy", bus.o_busy, active);
            if (!active) begin
                chk("idle_rd_req", bus.o_rd_req, 1'b0);
                chk("idle_buf_we", bus.o_buf_we, 1'b0);
                chk("idle_done", bus.o_req_done, 1'b0);
            end else begin
                if (m_iss - m_rcv > max_outst) max_outst = m_iss - m_rcv;
                chk("outst_le_max", (m_iss - m_rcv) <= MAX_OUTST, 1'b1);
                if (bus.o_rd_req && bus.i_rd_ready) begin
                    chk("rd_addr", bus.o_rd_addr, m_row_addr + 32'(m_iss * 8));
                    last_rd_addr = bus.o_rd_addr;
                    m_iss++;
                end
                if (bus.o_buf_we) begin
                    chk("we_in_range", m_wr < m_words, 1'b1);
                    if (m_wr < m_words) begin
                        chk("buf_bank", bus.o_buf_bank, m_bank);
                        chk("buf_addr", bus.o_buf_addr, m_wr);
                        chk("buf_wdata", bus.o_buf_wdata, mdata(m_row_addr + 32'(m_wr * 8)));
                    end
                    last_bank = int'(bus.o_buf_bank);
                    m_wr++;
                end
                if (bus.i_rd_vld && m_rcv < m_iss) begin
                    m_rcv++;
                    if (m_rcv == m_words) last_beat_cyc = cyc;
                end
                if (bus.o_req_done) begin
                    chk("done_writes", m_wr, m_words);
                    if (m_words > 0) chk("done_latency", cyc - last_beat_cyc, 2);
                    done_cnt++;
                    active = 0;
                end
            end
        end
    end

    // driver
    task automatic start(input int w, input int c, input int h, input logic [31:0] base, input int row);
        @(negedge clk);
        bus.q_width     = W_SIZE'(w);
        bus.q_channel   = W_CHANNEL'(c);
        bus.q_height    = W_SIZE'(h);
        bus.q_base_addr = base;
        bus.i_req_row   = W_SIZE'(row);
        bus.i_req_load  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_req_load = 1'b0;
        if (row < h) begin
            m_words    = w * c;
            m_row_addr = base + 32'(row * w * c * 8);
            m_bank     = row % IFM_BUF_CNT;
            m_iss = 0; m_rcv = 0; m_wr = 0; max_outst = 0;
            active = 1;
        end
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
            @(negedge clk);
            #3;
        end
        chk(name, done_cnt - d0, 1);
        active = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    int d_before;

    initial begin
        bus.q_width = '0; bus.q_height = '0; bus.q_channel = '0; bus.q_base_addr = '0;
        bus.i_req_load = 1'b0; bus.i_req_row = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_rd_req", bus.o_rd_req, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_done", bus.o_req_done, 1'b0);
        chk("rst_buf_we", bus.o_buf_we, 1'b0);
        chk("rst_rd_addr", bus.o_rd_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef IFM_ROW_LOADER_PERF_EN
        chk("perf_rst", perf_cnt, 32'd0);
        lat = 3;
        start(4, 4, 3, 32'h2000, 0);
        @(negedge clk); #3;
        stall_left = 5;
        wait_done("perf_done");
        chk("perf_stall_cnt", perf_cnt, 32'd5);
        idle_cycles(10);
`endif

        // basic row load, latency pinned by hand
        lat = 3;
        start(4, 2, 3, 32'h1000, 1);
        @(negedge clk); #3;
        chk("t1_addr_phase_no_req", bus.o_rd_req, 1'b0);
        @(negedge clk); #3;
        chk("t1_first_req", bus.o_rd_req, 1'b1);
        chk("t1_first_addr", bus.o_rd_addr, 32'h1040);
        wait_done("t1_done");
        chk("t1_last_addr", last_rd_addr, 32'h1078);
        chk("t1_writes", m_wr, 8);
        chk("t1_bank", last_bank, 1);
        idle_cycles(10);

        // throttled ready, long latency: outstanding cap reached
        rdy_alt = 1; lat = 20;
        start(4, 4, 3, 32'h1000, 2);
        wait_done("t2_done");
        chk("t2_max_outst", max_outst, 8);
        chk("t2_writes", m_wr, 16);
        chk("t2_bank", last_bank, 2);
        rdy_alt = 0; lat = 3;
        idle_cycles(30);

        // out-of-range row ignored
        start(4, 2, 3, 32'h1000, 5);
        idle_cycles(10);
        chk("t3_busy_ignored", bus.o_busy, 1'b0);

        // row 4 of 8 lands in bank 0; stray beat after the last one
        stray_after_last = 1;
        start(3, 1, 8, 32'h1000, 4);
        @(negedge clk); #3;
        @(negedge clk); #3;
        chk("t4_first_addr", bus.o_rd_addr, 32'h1060);
        wait_done("t4_done");
        chk("t4_bank", last_bank, 0);
        chk("t4_writes", m_wr, 3);
        idle_cycles(10);

        // request during FETCH ignored
        d_before = done_cnt;
        start(4, 2, 3, 32'h1000, 2);
        idle_cycles(4);
        @(negedge clk);
        bus.i_req_row = 10'd0; bus.i_req_load = 1'b1;
        @(negedge clk);
        bus.i_req_load = 1'b0;
        wait_done("t5_done");
        idle_cycles(20);
        chk("t5_single_done", done_cnt - d_before, 1);

        // zero-length row
        start(0, 2, 3, 32'h1000, 0);
        wait_done("t6_zero_done");
        chk("t6_zero_writes", m_wr, 0);
        idle_cycles(5);

        // reset mid-row after 3 beats
        d_before = done_cnt;
        start(4, 2, 3, 32'h1000, 1);
        for (int i = 0; i < 200 && m_rcv < 3; i++) begin
            @(negedge clk); #3;
        end
        chk("t7_three_beats", m_rcv, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        active = 0;
        chk("t7_rst_rd_req", bus.o_rd_req, 1'b0);
        chk("t7_rst_busy", bus.o_busy, 1'b0);
        chk("t7_rst_buf_we", bus.o_buf_we, 1'b0);
        chk("t7_rst_done", bus.o_req_done, 1'b0);
        chk("t7_rst_rd_addr", bus.o_rd_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(20);
        chk("t7_no_done", done_cnt - d_before, 0);
        chk("t7_late_beats_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
